mem_dump_sequencer: RTL

Debug-unit stage that sits directly downstream of the data memory's debug read port. After a start command it walks every byte of data memory in address order. For each address it drives the memory's debug read-enable and read-address, captures the registered byte one cycle later, and presents it to the UART transmitter over a valid/ready handshake. It signals completion with a one-cycle done pulse.

---
 rtl/mem_dump_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_dump_sequencer.sv
// -----------------------------------------------------------------------------
// mem_dump_sequencer
//
// Walks every entry of the data memory in ascending address order through its
// debug read port and hands each byte to the UART transmitter over a
// valid/ready handshake. A one-cycle done pulse marks the end of the dump.
//
// Per byte the sequence is READ -> LATCH -> SEND:
//   READ  : drive read enable and address; memory registers the byte
//   LATCH : the registered byte is on i_byte_data; capture it into o_tx_data
//   SEND  : offer o_tx_data until the transmitter accepts it
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_start        dump request, only honoured in IDLE
//   i_byte_data    registered byte from the memory debug port
//   i_tx_ready     transmitter accepts a byte this cycle
//   o_mem_enable   memory enable, high whenever a dump is in progress
//   o_read_enable  memory debug read enable (READ only)
//   o_read_address memory debug read address (0 in IDLE)
//   o_tx_data      byte offered to the transmitter
//   o_tx_valid     o_tx_data is valid
//   o_busy         dump in progress
//   o_done         one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module mem_dump_sequencer #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 128,
  parameter int NB_ADDR      = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [MEMORY_WIDTH-1:0] i_byte_data,
  input  logic                    i_tx_ready,
  output logic                    o_mem_enable,
  output logic                    o_read_enable,
  output logic [NB_ADDR-1:0]      o_read_address,
  output logic [MEMORY_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_DONE
  } state_e;

  // Termination is a compare against the last index, so the counter never
  // has to wrap and non power-of-two depths work unchanged.
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);

  state_e                  state_q,     state_d;
  logic [NB_ADDR-1:0]      addr_q,      addr_d;
  logic [MEMORY_WIDTH-1:0] tx_data_q,   tx_data_d;
  logic                    read_en_q,   read_en_d;
  logic [NB_ADDR-1:0]      read_addr_q, read_addr_d;
  logic                    tx_valid_q,  tx_valid_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        tx_data_d = i_byte_data;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every output reads zero while idle, including the data register.
    if (state_d == ST_IDLE) begin
      tx_data_d = '0;
    end
  end

  // Outputs are registered by decoding the next state, so each output lines
  // up with the state it belongs to and i_tx_ready never reaches an output
  // combinationally.
  always_comb begin
    read_en_d   = (state_d == ST_READ);
    tx_valid_d  = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    read_addr_d = (state_d == ST_IDLE) ? '0 : addr_d;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      tx_data_q   <= '0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_data_q   <= tx_data_d;
      read_en_q   <= read_en_d;
      read_addr_q <= read_addr_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_mem_enable   = busy_q;
  assign o_read_enable  = read_en_q;
  assign o_read_address = read_addr_q;
  assign o_tx_data      = tx_data_q;
  assign o_tx_valid     = tx_valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule
